// File: rtl/sd_fifo_head_b_pkg.sv
// rtl/sd_fifo_head_b_pkg.sv - pointer helpers shared by the FIFO head and tail blocks
package sd_fifo_head_b_pkg;

   // Helpers work on 32-bit values; callers cast their pointers in and the result back out.
   function automatic logic [31:0] wrap_inc(input logic [31:0] ptr,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
      return (ptr == hi) ? lo : ptr + 32'd1;
   endfunction

   function automatic logic [32:0] calc_usage(input logic [31:0] wr,
                                              input logic [31:0] rd,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
      logic [32:0] size;
      size = {1'b0, hi} - {1'b0, lo} + 33'd1;
      if (wr >= rd)
         return {1'b0, wr - rd};
      else
         return size - {1'b0, rd - wr};
   endfunction

endpackage

// File: rtl/sd_fifo_ptr_b.sv
// rtl/sd_fifo_ptr_b.sv - region-bounded pointer register with wrap increment and rewind load
module sd_fifo_ptr_b
   import sd_fifo_head_b_pkg::*;
#(
   parameter int asz = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [asz-1:0] bound_low_i,
   input  logic [asz-1:0] bound_high_i,
   input  logic           inc_i,
   input  logic           load_i,
   input  logic [asz-1:0] load_val_i,
   output logic [asz-1:0] ptr_o
);

   logic [asz-1:0] ptr_q;
   logic [asz-1:0] ptr_d;
   logic [asz-1:0] ptr_p1;

   assign ptr_p1 = asz'(wrap_inc(32'(ptr_q), 32'(bound_low_i), 32'(bound_high_i)));

   // A rewind load outranks an increment.
   always_comb begin
      ptr_d = ptr_q;
      if (load_i)
         ptr_d = load_val_i;
      else if (inc_i)
         ptr_d = ptr_p1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr_q <= bound_low_i;
      else
         ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sd_fifo_head_b.sv
// rtl/sd_fifo_head_b.sv - write side of a region-partitioned FIFO with optional commit/abort
module sd_fifo_head_b
   import sd_fifo_head_b_pkg::*;
#(
   parameter int width  = 8,
   parameter int depth  = 16,
   parameter int commit = 0,
   parameter int asz    = $clog2(depth),
   parameter int usz    = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [asz-1:0]   bound_low,
   input  logic [asz-1:0]   bound_high,
   input  logic [asz-1:0]   rdptr,
   output logic [asz-1:0]   cur_wrptr,
   output logic [asz-1:0]   com_wrptr,
   input  logic             c_srdy,
   output logic             c_drdy,
   input  logic [width-1:0] c_data,
   input  logic             c_commit,
   input  logic             c_abort,
   output logic             mem_we,
   output logic [asz-1:0]   mem_wr_addr,
   output logic [width-1:0] mem_wr_data,
   output logic [usz-1:0]   c_usage
);

   logic [asz-1:0] cur_wrptr_p1;
   logic           full;
   logic           abort_req;

   assign cur_wrptr_p1 = asz'(wrap_inc(32'(cur_wrptr), 32'(bound_low), 32'(bound_high)));
   assign full         = (cur_wrptr_p1 == rdptr);
   assign abort_req    = (commit != 0) && c_abort;

   // Reset gates the handshake so no write can slip out while pointers are forced.
   assign c_drdy      = !reset && enable && !full && !abort_req;
   assign mem_we      = c_srdy && c_drdy;
   assign mem_wr_addr = cur_wrptr;
   assign mem_wr_data = c_data;

   sd_fifo_ptr_b #(.asz(asz)) u_cur_ptr (
      .clk          (clk),
      .reset        (reset),
      .bound_low_i  (bound_low),
      .bound_high_i (bound_high),
      .inc_i        (mem_we),
      .load_i       (abort_req),
      .load_val_i   (com_wrptr),
      .ptr_o        (cur_wrptr)
   );

   generate
      if (commit != 0) begin : g_commit
         logic           com_load;
         logic [asz-1:0] com_val;

         // Abort wins; a commit alongside a write covers that word too.
         assign com_load = c_commit && !c_abort;
         assign com_val  = mem_we ? cur_wrptr_p1 : cur_wrptr;

         sd_fifo_ptr_b #(.asz(asz)) u_com_ptr (
            .clk          (clk),
            .reset        (reset),
            .bound_low_i  (bound_low),
            .bound_high_i (bound_high),
            .inc_i        (1'b0),
            .load_i       (com_load),
            .load_val_i   (com_val),
            .ptr_o        (com_wrptr)
         );
      end else begin : g_no_commit
         logic unused_commit;
         assign unused_commit = c_commit;
         assign com_wrptr     = cur_wrptr;
      end
   endgenerate

   assign c_usage = usz'(calc_usage(32'(cur_wrptr), 32'(rdptr), 32'(bound_low), 32'(bound_high)));

endmodule

// File: tb/tb_sd_fifo_head_b.sv
// tb/tb_sd_fifo_head_b.sv - self-checking bench for sd_fifo_head_b
module tb_sd_fifo_head_b;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] bound_low = 4'd0;
   logic [3:0] bound_high = 4'd15;
   logic [3:0] rdptr = 4'd0;
   logic       c_srdy = 1'b0;
   logic [7:0] c_data = 8'd0;
   logic       c_commit = 1'b0;
   logic       c_abort = 1'b0;

   logic [3:0] cur0, com0, addr0, cur1, com1, addr1;
   logic       drdy0, we0, drdy1, we1;
   logic [7:0] wdata0, wdata1;
   logic [4:0] usage0, usage1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sd_fifo_head_b #(.width(8), .depth(16), .commit(0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .bound_low(bound_low), .bound_high(bound_high),
      .rdptr(rdptr), .cur_wrptr(cur0), .com_wrptr(com0), .c_srdy(c_srdy), .c_drdy(drdy0),
      .c_data(c_data), .c_commit(c_commit), .c_abort(c_abort), .mem_we(we0),
      .mem_wr_addr(addr0), .mem_wr_data(wdata0), .c_usage(usage0)
   );

   sd_fifo_head_b #(.width(8), .depth(16), .commit(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .bound_low(bound_low), .bound_high(bound_high),
      .rdptr(rdptr), .cur_wrptr(cur1), .com_wrptr(com1), .c_srdy(c_srdy), .c_drdy(drdy1),
      .c_data(c_data), .c_commit(c_commit), .c_abort(c_abort), .mem_we(we1),
      .mem_wr_addr(addr1), .mem_wr_data(wdata1), .c_usage(usage1)
   );

   typedef struct {
      int en, srdy, data, cmt, abt, rd;
      int drdy, we, addr;
      int cur, com, usage;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(int en, int srdy, int data, int cmt, int abt, int rd,
                               int drdy, int we, int addr, int cur, int com, int usage);
      vec_t v;
      v.en = en; v.srdy = srdy; v.data = data; v.cmt = cmt; v.abt = abt; v.rd = rd;
      v.drdy = drdy; v.we = we; v.addr = addr; v.cur = cur; v.com = com; v.usage = usage;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset(int lo, int hi, int rd);
      @(negedge clk);
      bound_low  = 4'(lo);
      bound_high = 4'(hi);
      rdptr      = 4'(rd);
      enable     = 1'b1;
      c_srdy     = 1'b1;
      c_commit   = 1'b0;
      c_abort    = 1'b0;
      reset      = 1'b1;
      #1;
      check("reset drdy0", int'(drdy0), 0);
      check("reset we1", int'(we1), 0);
      check("reset cur1", int'(cur1), lo);
      check("reset com1", int'(com1), lo);
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      c_srdy = 1'b0;
      reset  = 1'b0;
   endtask

   task automatic write_word(int d);
      @(negedge clk);
      enable = 1'b1;
      c_srdy = 1'b1;
      c_data = 8'(d);
      @(posedge clk);
   endtask

   initial begin
      int nwe;
      int bad;
      // Sequence on the commit-enabled instance, region 0..7 (seven usable words).
      tbl[0]  = mk(1, 1, 'hA1, 0, 0, 0,  1, 1, 0,  1, 0, 1);
      tbl[1]  = mk(1, 1, 'hA2, 1, 0, 0,  1, 1, 1,  2, 2, 2);
      tbl[2]  = mk(1, 0, 'h00, 1, 0, 0,  1, 0, 2,  2, 2, 2);
      tbl[3]  = mk(0, 1, 'hB3, 0, 0, 0,  0, 0, 2,  2, 2, 2);
      tbl[4]  = mk(1, 1, 'hA4, 0, 0, 0,  1, 1, 2,  3, 2, 3);
      tbl[5]  = mk(1, 1, 'hA5, 1, 1, 0,  0, 0, 3,  2, 2, 2);
      tbl[6]  = mk(1, 1, 'hA6, 0, 0, 0,  1, 1, 2,  3, 2, 3);
      tbl[7]  = mk(0, 0, 'h00, 1, 0, 0,  0, 0, 3,  3, 3, 3);
      tbl[8]  = mk(1, 1, 'hA8, 0, 0, 5,  1, 1, 3,  4, 3, 7);
      tbl[9]  = mk(1, 1, 'hA9, 0, 0, 5,  0, 0, 4,  4, 3, 7);
      tbl[10] = mk(1, 1, 'hAA, 1, 0, 6,  1, 1, 4,  5, 5, 7);
      tbl[11] = mk(1, 1, 'hAB, 0, 0, 2,  1, 1, 5,  6, 5, 4);
      tbl[12] = mk(1, 1, 'hAC, 0, 0, 2,  1, 1, 6,  7, 5, 5);
      tbl[13] = mk(1, 1, 'hAD, 0, 0, 2,  1, 1, 7,  0, 5, 6);
      tbl[14] = mk(1, 1, 'hAE, 1, 0, 2,  1, 1, 0,  1, 1, 7);
      tbl[15] = mk(1, 1, 'hAF, 0, 0, 2,  0, 0, 1,  1, 1, 7);

      do_reset(0, 7, 0);
      #1;
      check("post-reset usage1", int'(usage1), 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         enable   = tbl[i].en[0];
         c_srdy   = tbl[i].srdy[0];
         c_data   = 8'(tbl[i].data);
         c_commit = tbl[i].cmt[0];
         c_abort  = tbl[i].abt[0];
         rdptr    = 4'(tbl[i].rd);
         #1;
         check($sformatf("row%0d drdy", i), int'(drdy1), tbl[i].drdy);
         check($sformatf("row%0d we", i), int'(we1), tbl[i].we);
         check($sformatf("row%0d addr", i), int'(addr1), tbl[i].addr);
         if (tbl[i].we != 0)
            check($sformatf("row%0d wdata", i), int'(wdata1), tbl[i].data);
         @(posedge clk);
         #1;
         check($sformatf("row%0d cur", i), int'(cur1), tbl[i].cur);
         check($sformatf("row%0d com", i), int'(com1), tbl[i].com);
         check($sformatf("row%0d usage", i), int'(usage1), tbl[i].usage);
      end

      // Fill a full 16-entry region with no commit support.
      do_reset(0, 15, 0);
      nwe = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         enable = 1'b1;
         c_srdy = 1'b1;
         c_data = 8'(i);
         c_commit = 1'b0;
         c_abort  = 1'b0;
         #1;
         if (we0) begin
            check($sformatf("fill addr%0d", nwe), int'(addr0), nwe);
            nwe++;
         end
         @(posedge clk);
      end
      #1;
      check("fill we count", nwe, 15);
      check("fill drdy", int'(drdy0), 0);
      check("fill usage", int'(usage0), 15);
      check("fill com0", int'(com0), 15);

      // Wrap inside region 4..9: advance to 8, move rdptr to 7, then write across the seam.
      do_reset(4, 9, 4);
      for (int i = 0; i < 4; i++) write_word(i);
      #1;
      check("wrap start cur", int'(cur0), 8);
      rdptr = 4'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         enable = 1'b1;
         c_srdy = 1'b1;
         #1;
         check($sformatf("wrap we%0d", i), int'(we0), 1);
         check($sformatf("wrap addr%0d", i), int'(addr0), (i == 0) ? 8 : (i == 1) ? 9 : 4);
         @(posedge clk);
      end
      #1;
      check("wrap cur", int'(cur0), 5);
      check("wrap usage", int'(usage0), 4);

      // Asynchronous reset mid-stream, region 3..12.
      do_reset(3, 12, 3);
      for (int i = 0; i < 5; i++) write_word(i);
      #1;
      check("midreset pre cur1", int'(cur1), 8);
      #2;
      reset = 1'b1;
      #1;
      check("midreset cur0", int'(cur0), 3);
      check("midreset cur1", int'(cur1), 3);
      check("midreset com1", int'(com1), 3);
      check("midreset drdy1", int'(drdy1), 0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (we0 || we1 || cur1 != 4'd3) bad++;
      end
      check("midreset held", bad, 0);
      @(negedge clk);
      enable = 1'b0;
      c_srdy = 1'b0;
      reset  = 1'b0;
      #1;
      check("midreset usage1", int'(usage1), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
